// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready channels,
// backed by a 64-bit-word RAM with a programmable response latency.
module dmem_responder #(
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [63:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int          AW     = $clog2(DEPTH_WORDS);
   localparam logic [63:0] SPAN   = 64'(DEPTH_WORDS) * 64'd8;
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        l_we;
   logic [63:0] l_addr;
   logic [1:0]  l_size;
   logic [63:0] l_wdata;

   logic [63:0] mem [DEPTH_WORDS];

   logic          s_we;
   logic [63:0]   s_addr;
   logic [1:0]    s_size;
   logic [63:0]   s_wdata;
   logic [63:0]   offset;
   logic [AW-1:0] idx;
   logic [2:0]    lane;
   logic [7:0]    be_base;
   logic [7:0]    be;
   logic [63:0]   size_mask;
   logic [63:0]   wsh;
   logic [63:0]   rd_data;
   logic          misaligned;
   logic          fault;
   logic          accept;
   logic          enter_resp;
   logic          commit;

   // With single-cycle latency the access decodes straight from the request.
   always_comb begin
      s_we    = (state == IDLE) ? req_we    : l_we;
      s_addr  = (state == IDLE) ? req_addr  : l_addr;
      s_size  = (state == IDLE) ? req_size  : l_size;
      s_wdata = (state == IDLE) ? req_wdata : l_wdata;
      offset  = s_addr - BASE_ADDR;
      idx     = offset[AW+2:3];
      lane    = offset[2:0];
      be_base    = 8'h01;
      size_mask  = 64'hFF;
      misaligned = 1'b0;
      unique case (s_size)
         2'd0: begin
            be_base    = 8'h01;
            size_mask  = 64'hFF;
            misaligned = 1'b0;
         end
         2'd1: begin
            be_base    = 8'h03;
            size_mask  = 64'hFFFF;
            misaligned = s_addr[0];
         end
         2'd2: begin
            be_base    = 8'h0F;
            size_mask  = 64'hFFFF_FFFF;
            misaligned = |s_addr[1:0];
         end
         2'd3: begin
            be_base    = 8'hFF;
            size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
            misaligned = |s_addr[2:0];
         end
      endcase
      be      = be_base << lane;
      wsh     = s_wdata << {lane, 3'b000};
      rd_data = (mem[idx] >> {lane, 3'b000}) & size_mask;
      fault   = (s_addr < BASE_ADDR) || (offset >= SPAN) || misaligned;
   end

   assign accept     = (state == IDLE) && req_valid && req_ready;
   assign enter_resp = (accept && (LATENCY == 1)) ||
                       ((state == WAIT) && (cnt == 4'd1));
   assign commit     = rst && enter_resp && s_we && !fault;

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 8; i++) begin
            if (be[i])
               mem[idx][8*i +: 8] <= wsh[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= 64'd0;
         resp_err   <= 1'b0;
         l_we       <= 1'b0;
         l_addr     <= 64'd0;
         l_size     <= 2'd0;
         l_wdata    <= 64'd0;
      end else begin
         unique case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  l_we      <= req_we;
                  l_addr    <= req_addr;
                  l_size    <= req_size;
                  l_wdata   <= req_wdata;
                  req_ready <= 1'b0;
                  cnt       <= LAT_M1;
                  state     <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_err   <= fault;
            resp_rdata <= (fault || s_we) ? 64'd0 : rd_data;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus backpressure and
// mid-transaction reset sequences.
module tb_dmem_responder;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [63:0] req_addr;
   logic [1:0]  req_size;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   int n_cmp = 0;
   int n_bad = 0;

   dmem_responder #(
      .BASE_ADDR(64'h8000_0000),
      .DEPTH_WORDS(1024),
      .LATENCY(LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_addr(req_addr),
      .req_size(req_size),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [1:0]  size;
      logic [63:0] wdata;
      logic [63:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called and returns at a falling edge.
   task automatic do_req(input logic we, input logic [63:0] addr,
                         input logic [1:0] size, input logic [63:0] wdata,
                         output logic [63:0] rd, output logic er,
                         output int lat);
      int n;
      req_we    = we;
      req_addr  = addr;
      req_size  = size;
      req_wdata = wdata;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", 64'(req_ready), 64'd1);
         req_valid = 1'b0;
         rd  = '0;
         er  = 1'b1;
         lat = -1;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 50);
      rd = resp_rdata;
      er = resp_err;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      logic [63:0] held;
      logic        er;
      int          lat;
      int          n;

      vecs[0]  = '{1'b1, 64'h8000_0008, 2'd3, 64'h1122_3344_5566_7788, 64'd0, 1'b0};
      vecs[1]  = '{1'b0, 64'h8000_0008, 2'd3, 64'd0, 64'h1122_3344_5566_7788, 1'b0};
      vecs[2]  = '{1'b1, 64'h8000_000A, 2'd0, 64'h0000_0000_0000_00FF, 64'd0, 1'b0};
      vecs[3]  = '{1'b0, 64'h8000_0008, 2'd3, 64'd0, 64'h1122_3344_55FF_7788, 1'b0};
      vecs[4]  = '{1'b0, 64'h8000_000A, 2'd0, 64'd0, 64'h0000_0000_0000_00FF, 1'b0};
      vecs[5]  = '{1'b0, 64'h8000_0009, 2'd1, 64'd0, 64'd0, 1'b1};
      vecs[6]  = '{1'b0, 64'h8000_0008, 2'd3, 64'd0, 64'h1122_3344_55FF_7788, 1'b0};
      vecs[7]  = '{1'b0, 64'h7FFF_FFF8, 2'd3, 64'd0, 64'd0, 1'b1};
      vecs[8]  = '{1'b1, 64'h7FFF_FFF8, 2'd3, 64'hDEAD, 64'd0, 1'b1};
      vecs[9]  = '{1'b0, 64'h8000_2000, 2'd3, 64'd0, 64'd0, 1'b1};
      vecs[10] = '{1'b1, 64'h8000_2000, 2'd3, 64'hBEEF, 64'd0, 1'b1};
      vecs[11] = '{1'b1, 64'h8000_1FF8, 2'd3, 64'hA5A5_5A5A_0F0F_F0F0, 64'd0, 1'b0};
      vecs[12] = '{1'b0, 64'h8000_1FF8, 2'd3, 64'd0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0};
      vecs[13] = '{1'b0, 64'h8000_000C, 2'd2, 64'd0, 64'h0000_0000_1122_3344, 1'b0};
      vecs[14] = '{1'b0, 64'h8000_000E, 2'd1, 64'd0, 64'h0000_0000_0000_1122, 1'b0};
      vecs[15] = '{1'b1, 64'h8000_0010, 2'd3, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0};

      rst        = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_size   = '0;
      req_wdata  = '0;
      resp_ready = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_rdata", resp_rdata, 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_req_ready", 64'(req_ready), 64'd1);

      for (int i = 0; i < 16; i++) begin
         do_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                rd, er, lat);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
      end

      // Backpressure: hold the response while a second request waits.
      do_req(1'b0, 64'h8000_0008, 2'd3, 64'd0, rd, er, lat);
      req_we    = 1'b0;
      req_addr  = 64'h8000_0008;
      req_size  = 2'd3;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_addr = 64'h8000_000C;
      req_size = 2'd2;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 50);
      held = resp_rdata;
      chk("bp_first_rdata", held, 64'h1122_3344_55FF_7788);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("bp_valid_c%0d", c), 64'(resp_valid), 64'd1);
         chk($sformatf("bp_rdata_c%0d", c), resp_rdata, held);
         chk($sformatf("bp_req_ready_c%0d", c), 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      chk("bp_valid_dropped", 64'(resp_valid), 64'd0);
      chk("bp_req_ready_next", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 50);
      chk("bp_second_latency", 64'(lat), 64'(LAT));
      chk("bp_second_rdata", resp_rdata, 64'h0000_0000_1122_3344);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);

      // Reset while a store waits: the store must be dropped.
      req_we    = 1'b1;
      req_addr  = 64'h8000_0010;
      req_size  = 2'd2;
      req_wdata = 64'h0000_0000_CAFE_F00D;
      req_valid = 1'b1;
      chk("wr_req_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("wait_resp_valid", 64'(resp_valid), 64'd0);
      chk("wait_req_ready", 64'(req_ready), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
      chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("mid_rst_resp_rdata", resp_rdata, 64'd0);
      chk("mid_rst_resp_err", 64'(resp_err), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);
      do_req(1'b0, 64'h8000_0010, 2'd3, 64'd0, rd, er, lat);
      chk("post_rst_old_value", rd, 64'h0123_4567_89AB_CDEF);
      chk("post_rst_err", 64'(er), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
